// File: rtl/obi_mem_pkg.sv
// Shared helpers for the obi_mem req/gnt/rvalid memory slave.
// Address decode and sizing functions used by the top and its response pipe.
package obi_mem_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned BITS_PER_LANE = 8;

    // Minimum 1 so that single-entry structures still get a legal vector width.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned byte_lanes(int unsigned data_width);
        return data_width / BITS_PER_LANE;
    endfunction

    // 64-bit size so DEPTH*bytes may reach the full 4 GiB window without wrapping.
    function automatic logic in_range(logic [ADDR_WIDTH-1:0] addr, logic [ADDR_WIDTH-1:0] base,
                                      logic [63:0] bytes);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - base;
        return (addr >= base) && ({32'd0, offset} < bytes);
    endfunction

endpackage

// File: rtl/obi_mem_resp_pipe.sv
// Fixed-latency response shift register; reset flushes every in-flight response.
// Stage 0 is loaded on the accept edge, the last stage drives the bus.
module obi_mem_resp_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_err,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } resp_t;

    resp_t r_stage [LATENCY];
    resp_t w_in;

    // Idle slots carry zeros so rdata/err read 0 whenever rvalid is low.
    assign w_in = '{valid: i_valid,
                    err:   i_valid & i_err,
                    rdata: i_valid ? i_rdata : '0};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= w_in;
            for (int s = 1; s < LATENCY; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_valid = r_stage[LATENCY-1].valid;
    assign o_err   = r_stage[LATENCY-1].err;
    assign o_rdata = r_stage[LATENCY-1].rdata;

endmodule

// File: rtl/obi_mem.sv
// Parametrised req/gnt/rvalid memory slave for core benches: latency, outstanding limit,
// periodic grant stalls, byte-enable writes and out-of-range error responses.
module obi_mem
    import obi_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STALL_PERIOD    = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    output logic                    o_gnt,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [31:0]             i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_rvalid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_err
);

    localparam int unsigned LANES      = byte_lanes(DATA_WIDTH);
    localparam int unsigned LANE_SHIFT = $clog2(LANES);
    localparam int unsigned IDX_W      = idx_width(DEPTH);
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STALL_W    = idx_width(STALL_PERIOD);
    localparam logic [63:0] MEM_BYTES  = 64'(DEPTH) * 64'(LANES);

    if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "obi_mem: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $fatal(1, "obi_mem: LATENCY must be >= 1");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
        $fatal(1, "obi_mem: MAX_OUTSTANDING must be >= 1");
    end
    if (STALL_PERIOD == 1) begin : g_bad_stall
        $fatal(1, "obi_mem: STALL_PERIOD of 1 would never grant");
    end
    if (BASE_ADDR % LANES != 0) begin : g_bad_base
        $fatal(1, "obi_mem: BASE_ADDR must be word aligned");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic              w_stall;
    logic              w_accept;
    logic              w_in_range;
    logic [31:0]       w_offset;
    logic [IDX_W-1:0]  w_index;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [OUT_W-1:0]  r_outst;
    logic [OUT_W-1:0]  w_outst_nxt;

    if (STALL_PERIOD >= 2) begin : g_stall
        logic [STALL_W-1:0] r_stall_cnt;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt == STALL_W'(STALL_PERIOD - 1)) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end

        assign w_stall = (r_stall_cnt == STALL_W'(STALL_PERIOD - 1));
    end else begin : g_no_stall
        assign w_stall = 1'b0;
    end

    // Registered count: a slot released by rvalid only becomes grantable next cycle.
    assign o_gnt    = i_req & ~i_rst & (r_outst < OUT_W'(MAX_OUTSTANDING)) & ~w_stall;
    assign w_accept = i_req & o_gnt;

    assign w_offset   = i_addr - BASE_ADDR;
    assign w_in_range = in_range(i_addr, BASE_ADDR, MEM_BYTES);
    assign w_index    = IDX_W'(w_offset >> LANE_SHIFT);
    assign w_rd_data  = (!i_we && w_in_range) ? mem[w_index] : '0;

    // No reset on the array: preloaded contents and accepted writes survive rst.
    always_ff @(posedge i_clk) begin
        if (w_accept && i_we && w_in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) begin
                    mem[w_index][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_accept, o_rvalid})
            2'b10:   w_outst_nxt = r_outst + 1'b1;
            2'b01:   w_outst_nxt = r_outst - 1'b1;
            default: w_outst_nxt = r_outst;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_nxt;
        end
    end

    obi_mem_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LATENCY)
    ) u_resp_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_accept),
        .i_err   (~w_in_range),
        .i_rdata (w_rd_data),
        .o_valid (o_rvalid),
        .o_err   (o_err),
        .o_rdata (o_rdata)
    );

endmodule

// File: tb/tb_obi_mem.sv
// Scoreboard bench for obi_mem: three instances (default, latency-3 windowed, stalling).
// Stimulus pushes expected responses; a negedge monitor pops and compares on rvalid.
module tb_obi_mem;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        req    [3];
    logic        we     [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic        err    [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [31:0] rdata  [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    int n_pass = 0;
    int n_checks = 0;
    int rv_cnt [3];
    int acc_cnt [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_mem u_a (
        .i_clk (clk), .i_rst (rst[0]), .i_req (req[0]), .o_gnt (gnt[0]), .i_we (we[0]),
        .i_be (be[0]), .i_addr (addr[0]), .i_wdata (wdata[0]), .o_rvalid (rvalid[0]),
        .o_rdata (rdata[0]), .o_err (err[0])
    );

    obi_mem #(
        .DEPTH (16), .BASE_ADDR (32'h100), .LATENCY (3), .MAX_OUTSTANDING (2)
    ) u_b (
        .i_clk (clk), .i_rst (rst[1]), .i_req (req[1]), .o_gnt (gnt[1]), .i_we (we[1]),
        .i_be (be[1]), .i_addr (addr[1]), .i_wdata (wdata[1]), .o_rvalid (rvalid[1]),
        .o_rdata (rdata[1]), .o_err (err[1])
    );

    obi_mem #(
        .STALL_PERIOD (4)
    ) u_c (
        .i_clk (clk), .i_rst (rst[2]), .i_req (req[2]), .o_gnt (gnt[2]), .i_we (we[2]),
        .i_be (be[2]), .i_addr (addr[2]), .i_wdata (wdata[2]), .o_rvalid (rvalid[2]),
        .o_rdata (rdata[2]), .o_err (err[2])
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int lat(int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic void qpush(int i, logic [31:0] d, logic e, int due);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.due   = due;
        case (i)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endfunction

    function automatic exp_t qpop(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rvalid[i] === 1'b1) begin
                exp_t e;
                rv_cnt[i]++;
                if (qsize(i) == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rvalid inst%0d: got rvalid=1 at cycle %0d expected none",
                             i, cyc);
                end else begin
                    e = qpop(i);
                    check($sformatf("rdata inst%0d", i), rdata[i], e.rdata);
                    check($sformatf("err inst%0d", i), {31'd0, err[i]}, {31'd0, e.err});
                    check($sformatf("rvalid_cycle inst%0d", i), cyc, e.due);
                end
            end
        end
    end

    // Called at posedge+1; holds req until granted and leaves at posedge+1 after the accept.
    task automatic xfer(int i, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] d,
                        logic [31:0] exp_rd, logic exp_err, output int waits);
        bit done = 1'b0;
        waits = 0;
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (gnt[i] === 1'b1) begin
                qpush(i, exp_rd, exp_err, cyc + lat(i));
                acc_cnt[i]++;
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        req[i] = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL gnt_timeout inst%0d: got no gnt expected gnt within 50 cycles", i);
        end
    endtask

    task automatic drain(int i);
        int t = 0;
        while (qsize(i) != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check($sformatf("drain inst%0d", i), qsize(i), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n;
        int rv_before;
        logic [0:5] pat_b;
        pat_b = 6'b110011;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; be[i] = '0;
            addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        req[0] = 1'b1;
        @(negedge clk);
        check("rst_gnt", {31'd0, gnt[0]}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid[0]}, 32'd0);
        check("rst_err", {31'd0, err[0]}, 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Instance A: latency 1, 1024 words at 0.
        xfer(0, 1'b1, 4'hF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, w);
        check("a_first_gnt_wait", w, 0);
        xfer(0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, w);
        xfer(0, 1'b1, 4'hF, 32'h4, 32'h0, 32'h0, 1'b0, w);
        xfer(0, 1'b1, 4'b0101, 32'h4, 32'h11223344, 32'h0, 1'b0, w);
        xfer(0, 1'b0, 4'h0, 32'h4, 32'h0, 32'h00220044, 1'b0, w);
        xfer(0, 1'b1, 4'h0, 32'h4, 32'hAAAAAAAA, 32'h0, 1'b0, w);
        xfer(0, 1'b0, 4'h0, 32'h4, 32'h0, 32'h00220044, 1'b0, w);
        xfer(0, 1'b0, 4'h0, 32'h7, 32'h0, 32'h00220044, 1'b0, w);
        xfer(0, 1'b1, 4'hF, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b0, w);
        xfer(0, 1'b0, 4'h0, 32'h8, 32'h0, 32'hFFFFFFFF, 1'b0, w);
        check("a_b2b_read_wait", w, 0);
        xfer(0, 1'b1, 4'hF, 32'hFFC, 32'h5A5A5A5A, 32'h0, 1'b0, w);
        xfer(0, 1'b0, 4'h0, 32'hFFC, 32'h0, 32'h5A5A5A5A, 1'b0, w);
        xfer(0, 1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1, w);
        xfer(0, 1'b1, 4'hF, 32'h1000, 32'h77777777, 32'h0, 1'b1, w);
        drain(0);

        // Instance B: latency 3, 16 words at 0x100.
        xfer(1, 1'b1, 4'hF, 32'h100, 32'h12345678, 32'h0, 1'b0, w);
        xfer(1, 1'b1, 4'hF, 32'h13C, 32'hCAFEF00D, 32'h0, 1'b0, w);
        drain(1);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("b_gnt_pattern c%0d", c), {31'd0, gnt[1]}, {31'd0, pat_b[c]});
            if (gnt[1] === 1'b1) begin
                qpush(1, 32'h12345678, 1'b0, cyc + 3);
                acc_cnt[1]++;
            end
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        drain(1);
        xfer(1, 1'b0, 4'h0, 32'h40, 32'h0, 32'h0, 1'b1, w);
        xfer(1, 1'b0, 4'h0, 32'hFC, 32'h0, 32'h0, 1'b1, w);
        xfer(1, 1'b0, 4'h0, 32'h140, 32'h0, 32'h0, 1'b1, w);
        xfer(1, 1'b1, 4'hF, 32'h140, 32'hDEADDEAD, 32'h0, 1'b1, w);
        xfer(1, 1'b1, 4'hF, 32'h40, 32'hBADBAD00, 32'h0, 1'b1, w);
        xfer(1, 1'b0, 4'h0, 32'h100, 32'h0, 32'h12345678, 1'b0, w);
        xfer(1, 1'b0, 4'h0, 32'h13C, 32'h0, 32'hCAFEF00D, 1'b0, w);
        drain(1);

        // Reset B with two reads in flight: no responses may follow.
        rv_before = rv_cnt[1];
        n = 0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h100;
        for (int t = 0; t < 10 && n < 2; t++) begin
            @(negedge clk);
            if (gnt[1] === 1'b1) n++;
            @(posedge clk); #1;
        end
        rst[1] = 1'b1;
        check("b_two_in_flight", n, 2);
        @(negedge clk);
        check("b_gnt_in_rst", {31'd0, gnt[1]}, 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b_no_rvalid_after_rst", rv_cnt[1] - rv_before, 0);
        xfer(1, 1'b0, 4'h0, 32'h100, 32'h0, 32'h12345678, 1'b0, w);
        check("b_gnt_after_rst", w, 0);
        drain(1);

        // Instance C: stall every 4th cycle counted from reset release.
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'h0; addr[2] = 32'h0;
        rst[2] = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            check($sformatf("c_gnt c%0d", c), {31'd0, gnt[2]}, {31'd0, ((c % 4) != 3)});
            if (gnt[2] === 1'b1) begin
                qpush(2, 32'h0, 1'b0, cyc + 1);
                acc_cnt[2]++;
            end
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        drain(2);
        check("c_accepts", acc_cnt[2], 10);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("resp_eq_accept inst%0d", i), rv_cnt[i], acc_cnt[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
